// File: rtl/ram_wait_pkg.sv
// Shared types and constants for the wait-state RAM model.
package ram_wait_pkg;

   // Width of the latency down-counter; latencies range over 0..15.
   localparam int CNT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_t;

endpackage

// File: rtl/ram_wait_array.sv
// Storage for the wait-state RAM: zero preload, one masked
// synchronous write port and one combinational read port.
module ram_wait_array #(
   parameter int    DATA_WIDTH    = 16,
   parameter int    ADDR_WIDTH    = 12,
   parameter string RAM_INIT_FILE = ""
)(
   input  logic                      i_clk,
   input  logic                      i_wen,
   input  logic [ADDR_WIDTH-1:0]     i_waddr,
   input  logic [DATA_WIDTH-1:0]     i_wdata,
   input  logic [DATA_WIDTH/8-1:0]   i_wbe,
   input  logic [ADDR_WIDTH-1:0]     i_raddr,
   output logic [DATA_WIDTH-1:0]     o_rdata
);
   import ram_wait_pkg::*;

   localparam int NUM_BYTES = DATA_WIDTH / 8;
   localparam int DEPTH     = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   // Memory starts cleared.
   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         r_mem[i] = '0;
      end
   end

   // Byte-masked write; lanes with a clear enable keep their old contents.
   always_ff @(posedge i_clk) begin
      if (i_wen) begin
         for (int i = 0; i < NUM_BYTES; i++) begin
            if (i_wbe[i]) begin
               r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
         end
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ram_wait_param.sv
// Parametrised single-port RAM with programmable read/write latency and a
// waitrequest stall handshake, intended as a memory model for CPU benches.
module ram_wait_param #(
   parameter int    DATA_WIDTH    = 16,
   parameter int    ADDR_WIDTH    = 12,
   parameter int    READ_LATENCY  = 0,
   parameter int    WRITE_LATENCY = 0,
   parameter string RAM_INIT_FILE = ""
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic [ADDR_WIDTH-1:0]     address,
   input  logic                      read,
   input  logic                      write,
   input  logic [DATA_WIDTH-1:0]     writedata,
   input  logic [DATA_WIDTH/8-1:0]   byteenable,
   output logic [DATA_WIDTH-1:0]     readdata,
   output logic                      waitrequest
);
   import ram_wait_pkg::*;

   localparam logic [CNT_WIDTH-1:0] RD_LAT  = CNT_WIDTH'(READ_LATENCY);
   localparam logic [CNT_WIDTH-1:0] WR_LAT  = CNT_WIDTH'(WRITE_LATENCY);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   state_t                    r_state;
   state_t                    w_nextState;
   logic [CNT_WIDTH-1:0]      r_cnt;
   op_t                       r_op;
   logic [ADDR_WIDTH-1:0]     r_addr;
   logic [DATA_WIDTH-1:0]     r_wdata;
   logic [DATA_WIDTH/8-1:0]   r_be;
   logic [DATA_WIDTH-1:0]     r_readdata;

   logic                      w_req;
   logic [CNT_WIDTH-1:0]      w_lat;
   logic                      w_stall;
   logic                      w_opLine;
   logic                      w_wen;
   logic [ADDR_WIDTH-1:0]     w_waddr;
   logic [DATA_WIDTH-1:0]     w_wdata;
   logic [DATA_WIDTH/8-1:0]   w_wbe;
   logic [DATA_WIDTH-1:0]     w_memRdata;

   // Write has priority when both request lines are high.
   assign w_req    = read | write;
   assign w_lat    = write ? WR_LAT : READ_LATENCY == 0 ? RD_LAT : RD_LAT;
   assign w_stall  = w_req && (w_lat != '0);
   assign w_opLine = (r_op == OP_WRITE) ? write : read;

   ram_wait_array #(
      .DATA_WIDTH    (DATA_WIDTH),
      .ADDR_WIDTH    (ADDR_WIDTH),
      .RAM_INIT_FILE (RAM_INIT_FILE)
   ) u_array (
      .i_clk   (clk),
      .i_wen   (w_wen),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_wbe   (w_wbe),
      .i_raddr (address),
      .o_rdata (w_memRdata)
   );

   // State register; reset abandons any transaction in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: stalled requests go through BUSY/DONE, and a dropped
   // request line during BUSY aborts back to IDLE so a misbehaving master
   // cannot wedge the memory.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_stall) begin
               w_nextState = (w_lat == CNT_ONE) ? DONE : BUSY;
            end
         end
         BUSY: begin
            if (!w_opLine) begin
               w_nextState = IDLE;
            end else if (r_cnt == CNT_ONE) begin
               w_nextState = DONE;
            end
         end
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Request capture and latency countdown; the read is taken at request
   // time so later address changes cannot disturb the returned data.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt      <= '0;
         r_op       <= OP_READ;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_be       <= '0;
         r_readdata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_stall) begin
                  r_cnt      <= w_lat - CNT_ONE;
                  r_op       <= write ? OP_WRITE : OP_READ;
                  r_addr     <= address;
                  r_wdata    <= writedata;
                  r_be       <= byteenable;
                  r_readdata <= w_memRdata;
               end
            end
            BUSY:    r_cnt <= r_cnt - CNT_ONE;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Output and memory-port muxing: zero-latency ops use the live inputs,
   // stalled writes commit from the latched copies in DONE.
   always_comb begin
      waitrequest = 1'b0;
      readdata    = r_readdata;
      w_wen       = 1'b0;
      w_waddr     = address;
      w_wdata     = writedata;
      w_wbe       = byteenable;
      case (r_state)
         IDLE: begin
            waitrequest = w_stall;
            if (write && (WR_LAT == '0)) begin
               w_wen = 1'b1;
            end
         end
         BUSY: waitrequest = 1'b1;
         DONE: begin
            if (r_op == OP_WRITE) begin
               w_wen   = 1'b1;
               w_waddr = r_addr;
               w_wdata = r_wdata;
               w_wbe   = r_be;
            end
         end
         default: waitrequest = 1'b0;
      endcase
      if (RD_LAT == '0) begin
         if ((r_state == IDLE) && read && !write) begin
            readdata = w_memRdata;
         end else begin
            readdata = 'x;
         end
      end
      if (reset) begin
         waitrequest = 1'b1;
         w_wen       = 1'b0;
      end
   end

endmodule

// File: tb/tb_ram_wait_param.sv
// Bench for ram_wait_param: four instances with different latency pairs share
// one stimulus bus; a transaction-level model checks every cycle and
// hand-computed pins anchor the model.
module tb_ram_wait_param;

   localparam int NDUT = 4;

   typedef struct {
      int          dut;
      string       name;
      logic        expWait;
      bit          chkData;
      logic [15:0] expData;
   } pin_t;

   logic             clk = 1'b0;
   logic             reset;
   logic [11:0]      address;
   logic [15:0]      writedata;
   logic [1:0]       byteenable;
   logic [NDUT-1:0]  rd;
   logic [NDUT-1:0]  wr;
   logic [15:0]      rdata [NDUT];
   logic             wreq  [NDUT];

   int checks = 0;
   int passed = 0;
   pin_t pinQ [$];

   logic [15:0] mm     [NDUT][4096] = '{default: '0};
   logic [15:0] rdHold [NDUT]       = '{default: '0};
   bit          act    [NDUT];
   int          left   [NDUT];
   bit          mOpW   [NDUT];
   logic [11:0] mAddr  [NDUT];
   logic [15:0] mData  [NDUT];
   logic [1:0]  mBe    [NDUT];

   always #5 clk = ~clk;

   ram_wait_param #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .READ_LATENCY(0), .WRITE_LATENCY(0), .RAM_INIT_FILE(""))
   dut0 (.clk(clk), .reset(reset), .address(address), .read(rd[0]), .write(wr[0]), .writedata(writedata),
         .byteenable(byteenable), .readdata(rdata[0]), .waitrequest(wreq[0]));

   ram_wait_param #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .READ_LATENCY(3), .WRITE_LATENCY(2), .RAM_INIT_FILE(""))
   dut1 (.clk(clk), .reset(reset), .address(address), .read(rd[1]), .write(wr[1]), .writedata(writedata),
         .byteenable(byteenable), .readdata(rdata[1]), .waitrequest(wreq[1]));

   ram_wait_param #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .READ_LATENCY(1), .WRITE_LATENCY(1), .RAM_INIT_FILE(""))
   dut2 (.clk(clk), .reset(reset), .address(address), .read(rd[2]), .write(wr[2]), .writedata(writedata),
         .byteenable(byteenable), .readdata(rdata[2]), .waitrequest(wreq[2]));

   ram_wait_param #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .READ_LATENCY(5), .WRITE_LATENCY(4), .RAM_INIT_FILE(""))
   dut3 (.clk(clk), .reset(reset), .address(address), .read(rd[3]), .write(wr[3]), .writedata(writedata),
         .byteenable(byteenable), .readdata(rdata[3]), .waitrequest(wreq[3]));

   function automatic int rlat(input int k);
      case (k)
         0:       return 0;
         1:       return 3;
         2:       return 1;
         default: return 5;
      endcase
   endfunction

   function automatic int wlat(input int k);
      case (k)
         0:       return 0;
         1:       return 2;
         2:       return 1;
         default: return 4;
      endcase
   endfunction

   function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] be);
      logic [15:0] r;
      r = old;
      if (be[0]) r[7:0]  = d[7:0];
      if (be[1]) r[15:8] = d[15:8];
      return r;
   endfunction

   task automatic checkOutput(input string name, input int k, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual === expected) begin
         passed++;
      end else begin
         $display("[TB] FAIL %s dut%0d: got %h, required %h", name, k, actual, expected);
      end
   endtask

   // Per-cycle model: each transaction lasts L+1 cycles with waitrequest high
   // for the first L; data read at request time; writes land at completion.
   always @(negedge clk) begin
      logic req;
      bit   isW;
      int   lat;
      bit   line;
      pin_t p;
      for (int k = 0; k < NDUT; k++) begin
         req = rd[k] | wr[k];
         isW = wr[k];
         lat = isW ? wlat(k) : rlat(k);
         if (reset) begin
            checkOutput("modelResetWait", k, 16'(wreq[k]), 16'h1);
            act[k]    = 1'b0;
            rdHold[k] = '0;
         end else if (!act[k]) begin
            if (req && lat == 0) begin
               checkOutput("modelL0Wait", k, 16'(wreq[k]), 16'h0);
               if (isW) mm[k][address] = merge(mm[k][address], writedata, byteenable);
               else     checkOutput("modelL0Data", k, rdata[k], mm[k][address]);
            end else if (req) begin
               checkOutput("modelReqWait", k, 16'(wreq[k]), 16'h1);
               if (rlat(k) > 0) checkOutput("modelReqHold", k, rdata[k], rdHold[k]);
               act[k]    = 1'b1;
               left[k]   = lat - 1;
               mOpW[k]   = isW;
               mAddr[k]  = address;
               mData[k]  = writedata;
               mBe[k]    = byteenable;
               rdHold[k] = mm[k][address];
            end else begin
               checkOutput("modelIdleWait", k, 16'(wreq[k]), 16'h0);
               if (rlat(k) > 0) checkOutput("modelIdleHold", k, rdata[k], rdHold[k]);
            end
         end else if (left[k] > 0) begin
            checkOutput("modelStallWait", k, 16'(wreq[k]), 16'h1);
            if (rlat(k) > 0) checkOutput("modelStallHold", k, rdata[k], rdHold[k]);
            line = mOpW[k] ? wr[k] : rd[k];
            if (!line) act[k] = 1'b0;
            else       left[k] = left[k] - 1;
         end else begin
            checkOutput("modelDoneWait", k, 16'(wreq[k]), 16'h0);
            if (rlat(k) > 0) checkOutput("modelDoneData", k, rdata[k], rdHold[k]);
            if (mOpW[k]) mm[k][mAddr[k]] = merge(mm[k][mAddr[k]], mData[k], mBe[k]);
            act[k] = 1'b0;
         end
      end
      while (pinQ.size() > 0) begin
         p = pinQ.pop_front();
         checkOutput({p.name, "Wait"}, p.dut, 16'(wreq[p.dut]), 16'(p.expWait));
         if (p.chkData) checkOutput({p.name, "Data"}, p.dut, rdata[p.dut], p.expData);
      end
   end

   task automatic pin(input int k, input string name, input logic w, input bit cd, input logic [15:0] d);
      pin_t p;
      p.dut = k; p.name = name; p.expWait = w; p.chkData = cd; p.expData = d;
      pinQ.push_back(p);
   endtask

   task automatic applyStimulus(input int k, input bit r, input bit w, input logic [11:0] a,
                                input logic [15:0] d, input logic [1:0] be);
      rd = '0;
      wr = '0;
      rd[k] = r;
      wr[k] = w;
      address = a;
      writedata = d;
      byteenable = be;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Holds one request for a hand-counted number of cycles; waitrequest is
   // pinned high on every cycle but the last, where data may also be pinned.
   task automatic runTxn(input int k, input bit r, input bit w, input logic [11:0] a, input logic [15:0] d,
                         input logic [1:0] be, input int cycles, input bit cd, input logic [15:0] ed,
                         input string name);
      for (int i = 0; i < cycles; i++) begin
         applyStimulus(k, r, w, a, d, be);
         pin(k, name, (i != cycles - 1), cd && (i == cycles - 1), ed);
         tick();
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1;
      applyStimulus(0, 0, 0, 12'd0, 16'h0, 2'b00);
      for (int k = 0; k < NDUT; k++) pin(k, "resetForced", 1'b1, 1'b0, 16'h0);
      tick();
      tick();
      reset = 1'b0;
      applyStimulus(0, 0, 0, 12'd0, 16'h0, 2'b00);
      pin(0, "postResetL0", 1'b0, 1'b0, 16'h0);
      pin(3, "postResetRd", 1'b0, 1'b1, 16'h0000);
      tick();

      // Zero latency: write then read back, plus an all-lanes-off write.
      runTxn(0, 0, 1, 12'd3, 16'hBEEF, 2'b11, 1, 0, 16'h0, "l0Write");
      runTxn(0, 1, 0, 12'd3, 16'h0000, 2'b00, 1, 1, 16'hBEEF, "l0Read");
      runTxn(0, 0, 1, 12'd3, 16'h0000, 2'b00, 1, 0, 16'h0, "l0MaskNone");
      runTxn(0, 1, 0, 12'd3, 16'h0000, 2'b00, 1, 1, 16'hBEEF, "l0ReadAfterMask");

      // Write latency 2 preload, read latency 3 fetch.
      runTxn(1, 0, 1, 12'd5, 16'h1234, 2'b11, 3, 0, 16'h0, "wl2Write");
      runTxn(1, 1, 0, 12'd5, 16'h0000, 2'b00, 4, 1, 16'h1234, "rl3Read");

      // Upper-byte write over 00CD; inputs wander during BUSY and a read
      // raised mid-write must wait for the write to finish.
      runTxn(1, 0, 1, 12'd10, 16'h00CD, 2'b11, 3, 0, 16'h0, "preloadCD");
      applyStimulus(1, 0, 1, 12'd10, 16'hAB00, 2'b10);
      pin(1, "maskReq", 1'b1, 1'b0, 16'h0);
      tick();
      applyStimulus(1, 1, 1, 12'd11, 16'h0000, 2'b11);
      pin(1, "maskBusy", 1'b1, 1'b0, 16'h0);
      tick();
      applyStimulus(1, 1, 1, 12'd11, 16'h0000, 2'b11);
      pin(1, "maskDone", 1'b0, 1'b1, 16'h00CD);
      tick();
      runTxn(1, 1, 0, 12'd10, 16'h0000, 2'b00, 4, 1, 16'hABCD, "maskRead");

      // Read and write together behave as a write.
      runTxn(2, 1, 1, 12'd7, 16'h5555, 2'b11, 2, 0, 16'h0, "bothHigh");
      runTxn(2, 1, 0, 12'd7, 16'h0000, 2'b00, 2, 1, 16'h5555, "bothRead");

      // Reset during a latency-4 write discards it.
      runTxn(3, 0, 1, 12'd9, 16'h1111, 2'b11, 5, 0, 16'h0, "preload9");
      runTxn(3, 1, 0, 12'd9, 16'h0000, 2'b00, 6, 1, 16'h1111, "read9");
      applyStimulus(3, 0, 1, 12'd9, 16'hFFFF, 2'b11);
      pin(3, "rstTxnReq", 1'b1, 1'b1, 16'h1111);
      tick();
      pin(3, "rstTxnBusy", 1'b1, 1'b0, 16'h0);
      tick();
      reset = 1'b1;
      pin(3, "rstInBusy", 1'b1, 1'b0, 16'h0);
      tick();
      reset = 1'b0;
      applyStimulus(3, 0, 0, 12'd9, 16'h0000, 2'b00);
      pin(3, "rstIdle", 1'b0, 1'b1, 16'h0000);
      tick();
      runTxn(3, 1, 0, 12'd9, 16'h0000, 2'b00, 6, 1, 16'h1111, "rstNoCommit");

      // Dropping read mid-BUSY aborts; the next read runs its full 6 cycles.
      applyStimulus(3, 1, 0, 12'd9, 16'h0000, 2'b00);
      pin(3, "abortReq", 1'b1, 1'b0, 16'h0);
      tick();
      pin(3, "abortBusy1", 1'b1, 1'b0, 16'h0);
      tick();
      applyStimulus(3, 0, 0, 12'd9, 16'h0000, 2'b00);
      pin(3, "abortDrop", 1'b1, 1'b0, 16'h0);
      tick();
      pin(3, "abortIdle", 1'b0, 1'b1, 16'h1111);
      tick();
      runTxn(3, 1, 0, 12'd9, 16'h0000, 2'b00, 6, 1, 16'h1111, "afterAbort");

      applyStimulus(0, 0, 0, 12'd0, 16'h0, 2'b00);
      tick();
      tick();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
